// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter with bus lock and alignment checking
module mem_arbiter #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_a,
    input  logic              we_a,
    input  logic              lock_a,
    input  logic [2:0]        funct3_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [31:0]       wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic              err_a,
    output logic [31:0]       rdata_a,

    input  logic              req_b,
    input  logic              we_b,
    input  logic              lock_b,
    input  logic [2:0]        funct3_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [31:0]       wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic              err_b,
    output logic [31:0]       rdata_b,

    output logic              MemRead,
    output logic              MemWrite,
    output logic [2:0]        funct3,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [31:0]       data_in,
    input  logic [31:0]       data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_gnt_b;   // 1 when port b held the most recent grant
    logic   mis_a;
    logic   mis_b;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic misaligned(input logic [2:0] f3, input logic [ADDR_W-1:0] addr);
        logic m;
        case (f3[1:0])
            2'b01:   m = addr[0];
            2'b10:   m = (addr[1:0] != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    assign mis_a = misaligned(funct3_a, addr_a);
    assign mis_b = misaligned(funct3_b, addr_b);

    // Ownership state register; reset always drops any lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection and next ownership; nothing is granted while in reset.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_a && req_b) begin
                        if (last_gnt_b) gnt_a = 1'b1;
                        else            gnt_b = 1'b1;
                    end else begin
                        gnt_a = req_a;
                        gnt_b = req_b;
                    end
                    if (gnt_a && lock_a) state_nxt = OWN_A;
                    if (gnt_b && lock_b) state_nxt = OWN_B;
                end
                OWN_A: begin
                    gnt_a = req_a;
                    if (!lock_a) state_nxt = IDLE;
                end
                OWN_B: begin
                    gnt_b = req_b;
                    if (!lock_b) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Memory port follows the granted requester; strobes suppressed on misalignment.
    always_comb begin
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'b000;
        byte_addr = '0;
        data_in   = 32'd0;
        if (gnt_a) begin
            MemRead   = !we_a && !mis_a;
            MemWrite  = we_a && !mis_a;
            funct3    = funct3_a;
            byte_addr = addr_a;
            data_in   = wdata_a;
        end else if (gnt_b) begin
            MemRead   = !we_b && !mis_b;
            MemWrite  = we_b && !mis_b;
            funct3    = funct3_b;
            byte_addr = addr_b;
            data_in   = wdata_b;
        end
    end

    // Remember who was granted last so contention alternates fairly.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_b <= 1'b1;
        end else if (gnt_a) begin
            last_gnt_b <= 1'b0;
        end else if (gnt_b) begin
            last_gnt_b <= 1'b1;
        end
    end

    // Port a response: one-cycle completion pulse, read data captured at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_a <= 1'b0;
            err_a    <= 1'b0;
            rdata_a  <= 32'd0;
        end else begin
            rvalid_a <= gnt_a;
            err_a    <= gnt_a && mis_a;
            if (gnt_a) begin
                rdata_a <= (mis_a || we_a) ? 32'd0 : data_out;
            end
        end
    end

    // Port b response: one-cycle completion pulse, read data captured at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_b <= 1'b0;
            err_b    <= 1'b0;
            rdata_b  <= 32'd0;
        end else begin
            rvalid_b <= gnt_b;
            err_b    <= gnt_b && mis_b;
            if (gnt_b) begin
                rdata_b <= (mis_b || we_b) ? 32'd0 : data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural ownership model
module tb_mem_arbiter;

    localparam int AW = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_a, we_a, lock_a;
    logic [2:0]     funct3_a;
    logic [AW-1:0]  addr_a;
    logic [31:0]    wdata_a;
    logic           req_b, we_b, lock_b;
    logic [2:0]     funct3_b;
    logic [AW-1:0]  addr_b;
    logic [31:0]    wdata_b;
    logic           gnt_a, rvalid_a, err_a;
    logic [31:0]    rdata_a;
    logic           gnt_b, rvalid_b, err_b;
    logic [31:0]    rdata_b;
    logic           MemRead, MemWrite;
    logic [2:0]     funct3;
    logic [AW-1:0]  byte_addr;
    logic [31:0]    data_in;
    logic [31:0]    data_out;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .lock_a(lock_a), .funct3_a(funct3_a),
        .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .err_a(err_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .lock_b(lock_b), .funct3_b(funct3_b),
        .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .err_b(err_b), .rdata_b(rdata_b),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .byte_addr(byte_addr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    int          total = 0;
    int          bad   = 0;
    resp_t       q_a[$];
    resp_t       q_b[$];
    logic [31:0] exp_rd_a = 32'd0;
    logic [31:0] exp_rd_b = 32'd0;
    bit          mon_en = 1'b0;

    // Environment memory (driven by the DUT) and reference memory (driven by the model).
    logic [7:0]    mem     [0:511];
    logic [7:0]    ref_mem [0:511];
    logic [AW-1:0] ba1, ba2, ba3;

    // Ownership model: 0 = nobody, 1 = a, 2 = b; last_b = b won most recently.
    int  owner  = 0;
    bit  last_b = 1'b1;
    bit  pred_a, pred_b;
    bit  obs_ga, obs_gb, obs_mr, obs_mw;

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3);
        logic [31:0] v;
        case (f3)
            3'b000:  v = {{24{w[7]}}, w[7:0]};
            3'b001:  v = {{16{w[15]}}, w[15:0]};
            3'b100:  v = {24'd0, w[7:0]};
            3'b101:  v = {16'd0, w[15:0]};
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [AW-1:0] a);
        int sz;
        if (f3[1:0] == 2'b11) return 1'b0;
        sz = 1 << f3[1:0];
        return (int'(a) % sz) != 0;
    endfunction

    assign ba1 = byte_addr + AW'(1);
    assign ba2 = byte_addr + AW'(2);
    assign ba3 = byte_addr + AW'(3);
    assign data_out = load_fmt({mem[ba3], mem[ba2], mem[ba1], mem[byte_addr]}, funct3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_a(input bit r, input bit w, input bit l, input logic [2:0] f,
                         input logic [AW-1:0] a, input logic [31:0] d);
        req_a = r; we_a = w; lock_a = l; funct3_a = f; addr_a = a; wdata_a = d;
    endtask

    task automatic set_b(input bit r, input bit w, input bit l, input logic [2:0] f,
                         input logic [AW-1:0] a, input logic [31:0] d);
        req_b = r; we_b = w; lock_b = l; funct3_b = f; addr_b = a; wdata_b = d;
    endtask

    // One clock: predict, check at negedge, then commit model and environment at posedge.
    task automatic run_cycle();
        bit            sel_w, mis, ew;
        logic [2:0]    sel_f, ef;
        logic [AW-1:0] sel_a, ea, ix;
        logic [31:0]   sel_d, ed;
        resp_t         r;
        int            nb;
        pred_a = 1'b0;
        pred_b = 1'b0;
        if (!rst) begin
            if (owner == 1)            pred_a = req_a;
            else if (owner == 2)       pred_b = req_b;
            else if (req_a && req_b) begin
                if (last_b) pred_a = 1'b1;
                else        pred_b = 1'b1;
            end else begin
                pred_a = req_a;
                pred_b = req_b;
            end
        end
        sel_w = 1'b0; sel_f = 3'd0; sel_a = '0; sel_d = 32'd0;
        if (pred_a) begin
            sel_w = we_a; sel_f = funct3_a; sel_a = addr_a; sel_d = wdata_a;
        end else if (pred_b) begin
            sel_w = we_b; sel_f = funct3_b; sel_a = addr_b; sel_d = wdata_b;
        end
        mis = (pred_a || pred_b) && is_mis(sel_f, sel_a);

        @(negedge clk);
        obs_ga = gnt_a; obs_gb = gnt_b; obs_mr = MemRead; obs_mw = MemWrite;
        chk("gnt_a", 32'(gnt_a), 32'(pred_a));
        chk("gnt_b", 32'(gnt_b), 32'(pred_b));
        chk("MemRead", 32'(MemRead), 32'((pred_a || pred_b) && !sel_w && !mis));
        chk("MemWrite", 32'(MemWrite), 32'((pred_a || pred_b) && sel_w && !mis));
        chk("funct3", 32'(funct3), 32'(sel_f));
        chk("byte_addr", 32'(byte_addr), 32'(sel_a));
        chk("data_in", data_in, sel_d);
        ew = MemWrite; ef = funct3; ea = byte_addr; ed = data_in;

        @(posedge clk);
        if (ew === 1'b1) begin
            nb = 1 << ef[1:0];
            for (int k = 0; k < nb; k++) begin
                ix = ea + AW'(k);
                mem[ix] = ed[8*k +: 8];
            end
        end
        if (rst) begin
            owner = 0; last_b = 1'b1; exp_rd_a = 32'd0; exp_rd_b = 32'd0; mon_en = 1'b1;
        end else begin
            if (pred_a || pred_b) begin
                r.err = mis;
                if (mis || sel_w) begin
                    r.rdata = 32'd0;
                end else begin
                    r.rdata = load_fmt({ref_mem[sel_a + AW'(3)], ref_mem[sel_a + AW'(2)],
                                        ref_mem[sel_a + AW'(1)], ref_mem[sel_a]}, sel_f);
                end
                if (sel_w && !mis) begin
                    nb = 1 << sel_f[1:0];
                    for (int k = 0; k < nb; k++) begin
                        ix = sel_a + AW'(k);
                        ref_mem[ix] = sel_d[8*k +: 8];
                    end
                end
                if (pred_a) begin q_a.push_back(r); exp_rd_a = r.rdata; last_b = 1'b0; end
                else        begin q_b.push_back(r); exp_rd_b = r.rdata; last_b = 1'b1; end
            end
            if (owner == 1)                 owner = lock_a ? 1 : 0;
            else if (owner == 2)            owner = lock_b ? 2 : 0;
            else if (pred_a && lock_a)      owner = 1;
            else if (pred_b && lock_b)      owner = 2;
        end
        #1;
    endtask

    // Response monitor: a completion is due exactly when the scoreboard holds one.
    always @(negedge clk) begin : monitor
        resp_t r;
        if (mon_en) begin
            if (q_a.size() > 0) begin
                r = q_a.pop_front();
                chk("rvalid_a", 32'(rvalid_a), 32'd1);
                chk("err_a", 32'(err_a), 32'(r.err));
            end else begin
                chk("rvalid_a_idle", 32'(rvalid_a), 32'd0);
                chk("err_a_idle", 32'(err_a), 32'd0);
            end
            chk("rdata_a", rdata_a, exp_rd_a);
            if (q_b.size() > 0) begin
                r = q_b.pop_front();
                chk("rvalid_b", 32'(rvalid_b), 32'd1);
                chk("err_b", 32'(err_b), 32'(r.err));
            end else begin
                chk("rvalid_b_idle", 32'(rvalid_b), 32'd0);
                chk("err_b_idle", 32'(err_b), 32'd0);
            end
            chk("rdata_b", rdata_b, exp_rd_b);
        end
    end

    // Random transaction fields for a port: legal load/store encodings, any address.
    task automatic rand_txn(output bit w, output bit l, output logic [2:0] f,
                            output logic [AW-1:0] a, output logic [31:0] d);
        logic [2:0] ld [5];
        ld[0] = 3'b000; ld[1] = 3'b001; ld[2] = 3'b010; ld[3] = 3'b100; ld[4] = 3'b101;
        w = 1'($urandom_range(0, 1));
        l = ($urandom_range(0, 3) == 0);
        f = w ? 3'($urandom_range(0, 2)) : ld[$urandom_range(0, 4)];
        a = AW'($urandom);
        d = $urandom;
    endtask

    initial begin : driver
        bit            pend_a, pend_b, tw, tl;
        logic [2:0]    tf;
        logic [AW-1:0] ta;
        logic [31:0]   td;
        bit            seq_a [4];
        bit            seq_b [4];
        int            diffs;

        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[9'h100] = 8'd17; mem[9'h101] = 8'd0; mem[9'h102] = 8'd0; mem[9'h103] = 8'd0;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];

        rst = 1'b1;
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        set_b(0, 0, 0, 3'b000, '0, 32'd0);
        run_cycle();
        run_cycle();
        rst = 1'b0;
        chk("reset_rvalid_a", 32'(rvalid_a), 32'd0);
        chk("reset_err_b", 32'(err_b), 32'd0);
        chk("reset_rdata_a", rdata_a, 32'd0);
        chk("reset_rdata_b", rdata_b, 32'd0);

        // Single aligned read of word 64.
        set_a(1, 0, 0, 3'b010, 9'h100, 32'd0);
        run_cycle();
        chk("rd_gnt_a", 32'(obs_ga), 32'd1);
        chk("rd_memread", 32'(obs_mr), 32'd1);
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        chk("rd_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("rd_rdata_a", rdata_a, 32'd17);
        chk("rd_err_a", 32'(err_a), 32'd0);
        run_cycle();

        // Contention after reset alternates a, b, a, b.
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        set_a(1, 0, 0, 3'b010, 9'h100, 32'd0);
        set_b(1, 0, 0, 3'b010, 9'h104, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            seq_a[i] = obs_ga;
            seq_b[i] = obs_gb;
            chk("contend_not_both", 32'(obs_ga && obs_gb), 32'd0);
        end
        chk("contend_seq_a", {28'd0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'b1010);
        chk("contend_seq_b", {28'd0, seq_b[0], seq_b[1], seq_b[2], seq_b[3]}, 32'b0101);
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        set_b(0, 0, 0, 3'b000, '0, 32'd0);
        run_cycle();

        // Lock: b stores a byte then reads it back while a waits.
        set_b(1, 1, 1, 3'b000, 9'h104, 32'h000000AA);
        run_cycle();
        chk("lock_gnt_b_sb", 32'(obs_gb), 32'd1);
        set_a(1, 0, 0, 3'b010, 9'h100, 32'd0);
        set_b(1, 0, 0, 3'b100, 9'h104, 32'd0);
        run_cycle();
        chk("lock_a_waits", 32'(obs_ga), 32'd0);
        chk("lock_gnt_b_lbu", 32'(obs_gb), 32'd1);
        set_b(0, 0, 0, 3'b000, '0, 32'd0);
        chk("lock_rdata_b", rdata_b, 32'h000000AA);
        run_cycle();
        chk("lock_a_next", 32'(obs_ga), 32'd1);
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        run_cycle();

        // Misaligned word read on a.
        set_a(1, 0, 0, 3'b010, 9'h102, 32'd0);
        run_cycle();
        chk("mis_rd_gnt_a", 32'(obs_ga), 32'd1);
        chk("mis_rd_memread", 32'(obs_mr), 32'd0);
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        chk("mis_rd_err_a", 32'(err_a), 32'd1);
        chk("mis_rd_rvalid_a", 32'(rvalid_a), 32'd1);
        chk("mis_rd_rdata_a", rdata_a, 32'd0);
        run_cycle();

        // Misaligned halfword write on b.
        set_b(1, 1, 0, 3'b001, 9'h101, 32'h0000BEEF);
        run_cycle();
        chk("mis_wr_gnt_b", 32'(obs_gb), 32'd1);
        chk("mis_wr_memwrite", 32'(obs_mw), 32'd0);
        set_b(0, 0, 0, 3'b000, '0, 32'd0);
        chk("mis_wr_err_b", 32'(err_b), 32'd1);
        chk("mis_wr_rvalid_b", 32'(rvalid_b), 32'd1);
        run_cycle();
        chk("word64_intact", {mem[9'h103], mem[9'h102], mem[9'h101], mem[9'h100]}, 32'd17);

        // Reset while b owns the bus: no grants during reset, a wins afterwards.
        set_b(1, 1, 1, 3'b010, 9'h108, 32'h12345678);
        run_cycle();
        rst = 1'b1;
        set_a(1, 0, 0, 3'b010, 9'h100, 32'd0);
        set_b(1, 0, 1, 3'b010, 9'h104, 32'd0);
        run_cycle();
        chk("rstlock_no_gnt_a", 32'(obs_ga), 32'd0);
        chk("rstlock_no_gnt_b", 32'(obs_gb), 32'd0);
        chk("rstlock_no_write", 32'(obs_mw), 32'd0);
        rst = 1'b0;
        run_cycle();
        chk("rstlock_a_first", 32'(obs_ga), 32'd1);
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        run_cycle();
        set_b(0, 0, 0, 3'b000, '0, 32'd0);
        run_cycle();

        // Randomised traffic; requesters hold their fields until the model grants them.
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!pend_a) begin
                if ($urandom_range(0, 2) != 0) begin
                    rand_txn(tw, tl, tf, ta, td);
                    set_a(1, tw, tl, tf, ta, td);
                    pend_a = 1'b1;
                end else begin
                    set_a(0, 0, ($urandom_range(0, 3) == 0), 3'b000, '0, 32'd0);
                end
            end
            if (!pend_b) begin
                if ($urandom_range(0, 2) != 0) begin
                    rand_txn(tw, tl, tf, ta, td);
                    set_b(1, tw, tl, tf, ta, td);
                    pend_b = 1'b1;
                end else begin
                    set_b(0, 0, ($urandom_range(0, 3) == 0), 3'b000, '0, 32'd0);
                end
            end
            rst = ($urandom_range(0, 63) == 0);
            run_cycle();
            if (pred_a) pend_a = 1'b0;
            if (pred_b) pend_b = 1'b0;
        end
        rst = 1'b0;
        set_a(0, 0, 0, 3'b000, '0, 32'd0);
        set_b(0, 0, 0, 3'b000, '0, 32'd0);
        run_cycle();
        run_cycle();

        diffs = 0;
        for (int i = 0; i < 512; i++) begin
            if (mem[i] !== ref_mem[i]) diffs++;
        end
        chk("mem_image_diffs", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width shared by both ports and the memory port.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have per-port inputs, x in {a,b}: req_x 1, we_x 1, lock_x 1, funct3_x 3, addr_x ADDR_W, wdata_x 32; a = CPU data port, b = secondary (loader/debug) port.
REQ-005 SHALL have per-port outputs: gnt_x 1, rvalid_x 1, err_x 1, rdata_x 32.
REQ-006 SHALL have memory-side outputs MemRead 1, MemWrite 1, funct3 3, byte_addr ADDR_W, data_in 32, and input data_out 32 (combinational read data).

Function
REQ-007 SHALL use handshake: requester holds req_x and its fields stable until gnt_x; transfer occurs in the cycle req_x && gnt_x.
REQ-008 SHALL assert gnt to at most one port per cycle; gnt_x is combinational from the current req and state.
REQ-009 SHALL have state machine IDLE, OWN_A, OWN_B; reset state IDLE.
REQ-010 IDLE: one requester -> grant it; both -> grant the port not granted last (last_gnt register, reset value b, so a wins first contention).
REQ-011 SHALL transition IDLE -> OWN_x when port x is granted with lock_x=1; stay IDLE otherwise.
REQ-012 OWN_x: only port x may be granted; the other port waits regardless of its req.
REQ-013 OWN_x: granted access with lock_x=0 returns to IDLE after that access; lock_x=0 with no req_x also returns to IDLE, with no grant that cycle.
REQ-014 SHALL drive memory signals from the granted port in the grant cycle: MemWrite=we_x, MemRead=!we_x, funct3/byte_addr/data_in from port x; all memory outputs 0 when no grant.
REQ-015 Alignment: LH/LHU/SH (funct3[1:0]=01) with addr[0]=1, and LW/SW (funct3[1:0]=10) with addr[1:0]!=0, are misaligned.
REQ-016 Misaligned access: gnt_x still asserted, MemRead and MemWrite held 0, and one cycle later err_x=1, rvalid_x=1, rdata_x=0.
REQ-017 Aligned read: data_out registered into rdata_x at the grant-cycle edge; rvalid_x=1 exactly one cycle after grant, for one cycle.
REQ-018 Aligned write: rvalid_x=1, err_x=0, rdata_x=0 one cycle after grant (write acknowledge).
REQ-019 rdata_x of the non-granted port SHALL hold its previous value; rvalid/err of a port are 0 in any cycle not following its grant.
REQ-020 last_gnt SHALL update on every grant, including misaligned ones.
REQ-021 Back-to-back grants to the same port in consecutive cycles SHALL be allowed (throughput one access per cycle).

Reset
REQ-022 When rst=1 at a clock edge: state IDLE, last_gnt=b, rvalid_x=0, err_x=0, rdata_x=0.
REQ-023 While rst=1: gnt_x=0 and MemRead/MemWrite=0 combinationally, so no memory write happens during reset; a request pending across reset is re-arbitrated from IDLE.
REQ-024 Reset asserted in OWN_x SHALL drop the lock; the first post-reset grant follows REQ-010.

Verification
REQ-025 Single read: req_a, we_a=0, funct3=010, addr_a=0x100 (word 64=17) -> gnt_a same cycle, MemRead=1, next cycle rvalid_a=1, rdata_a=17, err_a=0.
REQ-026 Contention: req_a and req_b held high 4 cycles after reset -> grants a,b,a,b; never both in one cycle.
REQ-027 Lock: b granted with lock_b=1 writes SB 0xAA to 0x104, then a requests while b does LBU 0x104 with lock_b=0 -> a waits, b gets rdata_b=0x000000AA, a granted the next cycle.
REQ-028 Misaligned: req_a LW addr 0x102 -> gnt_a, MemRead=0, next cycle err_a=1, rvalid_a=1, rdata_a=0; word 64 unchanged.
REQ-029 Misaligned write: req_b SH addr 0x101, wdata 0xBEEF -> gnt_b, MemWrite=0, next cycle err_b=1, rvalid_b=1; memory word 64 unchanged.
REQ-030 Reset mid-lock: in OWN_b, assert rst one cycle with req_a and req_b high -> no grants, MemWrite=0 during reset; after release a granted first.
